mux_stream_arb: RTL

//  Parametrised N-channel registered stream multiplexer; next generation of the 3-input combinational mux.

---
 rtl/mux_stream_if.sv | 43 ++++
 rtl/mux_stream_arb.sv | 86 ++++++++
 2 files changed

// File: rtl/mux_stream_if.sv
// mux_stream_if: handshake bundle between N channel sources, the stream mux and one shared sink.
// Parameters: WIDTH data bits per channel, CHANNELS input count; SELW is derived.
// Signals:
//   in_data/in_valid/in_ready  per-channel input streams, channel k on in_data[k*WIDTH +: WIDTH]
//   mode/sel                   0 = fixed select on sel, 1 = round-robin
//   out_data/out_chan/out_valid/out_ready  registered output stream and source channel id
//   in_last/out_last           packet delimiters, present only with MUX_PKT_LOCK_EN defined
// Modports: slave = mux side, master = sources and sink side.
interface mux_stream_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_valid;
    logic                      out_ready;
`ifdef MUX_PKT_LOCK_EN
    logic [CHANNELS-1:0]       in_last;
    logic                      out_last;
`endif
    modport slave (
`ifdef MUX_PKT_LOCK_EN
        input  in_last,
        output out_last,
`endif
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
    modport master (
`ifdef MUX_PKT_LOCK_EN
        output in_last,
        input  out_last,
`endif
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_stream_arb.sv
// mux_stream_arb: N-channel stream mux with fixed-select or round-robin grant into a one-deep output register.
// Ports: clk, rst_n (async active-low), bus (mux_stream_if.slave: per-channel inputs, mode/sel, output stream).
// Optional feature: MUX_PKT_LOCK_EN adds in_last/out_last and holds the grant on one channel until in_last.
module mux_stream_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_stream_if.slave bus
);
    localparam int SELW = $clog2(CHANNELS);
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_chan_q, out_chan_d, rr_ptr_q, rr_ptr_d, gidx, k;
    logic             out_valid_q, out_valid_d, gany, can_load, accept;
`ifdef MUX_PKT_LOCK_EN
    logic             lock_q, lock_d, out_last_q, out_last_d;
    logic [SELW-1:0]  lock_chan_q, lock_chan_d;
`endif
    always_comb begin
        gany = 1'b0;
        gidx = '0;
        k    = '0;
        if (bus.mode) begin
            // first valid channel at or after rr_ptr, wrapping through 0
            for (int i = 0; i < CHANNELS; i++) begin
                k = SELW'((int'(rr_ptr_q) + i) % CHANNELS);
                if (!gany && bus.in_valid[k]) begin
                    gany = 1'b1;
                    gidx = k;
                end
            end
        end else begin
            gany = (int'(bus.sel) < CHANNELS) && bus.in_valid[bus.sel];
            gidx = bus.sel;
        end
`ifdef MUX_PKT_LOCK_EN
        if (lock_q) begin
            gany = bus.in_valid[lock_chan_q];
            gidx = lock_chan_q;
        end
`endif
        can_load    = !out_valid_q || bus.out_ready;
        // rst_n gates accept so in_ready stays low while reset is held
        accept      = gany && can_load && rst_n;
        out_valid_d = accept || (out_valid_q && !bus.out_ready);
        out_data_d  = accept ? bus.in_data[gidx*WIDTH +: WIDTH] : out_data_q;
        out_chan_d  = accept ? gidx : out_chan_q;
        rr_ptr_d    = accept ? ((int'(gidx) == CHANNELS-1) ? '0 : gidx + 1'b1) : rr_ptr_q;
`ifdef MUX_PKT_LOCK_EN
        lock_d      = accept ? !bus.in_last[gidx] : lock_q;
        lock_chan_d = accept ? gidx : lock_chan_q;
        out_last_d  = accept ? bus.in_last[gidx] : out_last_q;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
`ifdef MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
            out_last_q  <= out_last_d;
`endif
        end
    end
    assign bus.in_ready  = accept ? (CHANNELS'(1) << gidx) : '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
`ifdef MUX_PKT_LOCK_EN
    assign bus.out_last  = out_last_q;
`endif
endmodule
